// File: rtl/coeff_pkg.sv
// Shared types and constants for the coefficient load responder.
// Consumers: coeff_bank and coeff_load_responder.
package coeff_pkg;

    localparam int unsigned DEFAULT_COEFF_W = 16;
    localparam int unsigned NUM_COEFF       = 4;
    localparam int unsigned IDX_W           = 2;
    // Wide enough for the maximum LOAD_CYCLES of 15.
    localparam int unsigned CNT_W           = 4;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

endpackage

// File: rtl/coeff_bank.sv
// Four-entry coefficient register file with single-entry write and whole-bank parallel load.
// The parallel load takes priority over the single-entry write.
module coeff_bank
    import coeff_pkg::*;
#(
    parameter int unsigned COEFF_W = DEFAULT_COEFF_W
) (
    input  logic                              clk,
    input  logic                              n_reset,
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [COEFF_W-1:0]                wr_data,
    input  logic                              ld_en,
    input  logic [NUM_COEFF-1:0][COEFF_W-1:0] ld_data,
    output logic [NUM_COEFF-1:0][COEFF_W-1:0] rd_data
);

    logic [NUM_COEFF-1:0][COEFF_W-1:0] regs_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            regs_q <= '0;
        end else if (ld_en) begin
            regs_q <= ld_data;
        end else if (wr_en) begin
            regs_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = regs_q;

endmodule

// File: rtl/coeff_load_responder.sv
// Accepts coefficient loads, holds modwait for LOAD_CYCLES cycles, then commits to the bank.
// Define COEFF_SHADOW_EN to stage writes in a shadow bank and publish a complete set atomically.
module coeff_load_responder
    import coeff_pkg::*;
#(
    parameter int unsigned COEFF_W     = DEFAULT_COEFF_W,
    parameter int unsigned LOAD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               load_coeff,
    input  logic [IDX_W-1:0]   coefficient_num,
    input  logic [COEFF_W-1:0] coeff_in,
    output logic               modwait,
    output logic [COEFF_W-1:0] coeff0,
    output logic [COEFF_W-1:0] coeff1,
    output logic [COEFF_W-1:0] coeff2,
    output logic [COEFF_W-1:0] coeff3,
    output logic               set_done,
    output logic               overrun
);

    localparam logic [CNT_W-1:0] LoadCnt = CNT_W'(LOAD_CYCLES);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [COEFF_W-1:0]   data_q, data_d;
    logic [NUM_COEFF-1:0] mask_q, mask_d;
    logic [NUM_COEFF-1:0] mask_set;
    logic                 modwait_q, modwait_d;
    logic                 set_done_q, set_done_d;
    logic                 overrun_q, overrun_d;
    logic                 wr_en;

    logic [NUM_COEFF-1:0][COEFF_W-1:0] active_rd;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            modwait_q  <= 1'b0;
            set_done_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            modwait_q  <= modwait_d;
            set_done_q <= set_done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign mask_set = mask_q | (NUM_COEFF'(1) << idx_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        mask_d     = mask_q;
        modwait_d  = modwait_q;
        set_done_d = 1'b0;
        overrun_d  = 1'b0;
        wr_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load_coeff) begin
                    idx_d     = coefficient_num;
                    data_d    = coeff_in;
                    cnt_d     = LoadCnt;
                    modwait_d = 1'b1;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                // Requests while busy are dropped; only flagged.
                overrun_d = load_coeff;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    wr_en     = 1'b1;
                    modwait_d = 1'b0;
                    state_d   = StIdle;
                    if (&mask_set) begin
                        mask_d     = '0;
                        set_done_d = 1'b1;
                    end else begin
                        mask_d = mask_set;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef COEFF_SHADOW_EN
    logic [NUM_COEFF-1:0][COEFF_W-1:0] shadow_rd;
    logic [NUM_COEFF-1:0][COEFF_W-1:0] copy_data;
    logic                              copy_en;

    coeff_bank #(
        .COEFF_W (COEFF_W)
    ) u_shadow_bank (
        .clk     (clk),
        .n_reset (n_reset),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (data_q),
        .ld_en   (1'b0),
        .ld_data ('0),
        .rd_data (shadow_rd)
    );

    // The completing write is merged in so the active copy sees the full set on the same edge.
    always_comb begin
        copy_data        = shadow_rd;
        copy_data[idx_q] = data_q;
    end

    assign copy_en = wr_en & set_done_d;

    coeff_bank #(
        .COEFF_W (COEFF_W)
    ) u_active_bank (
        .clk     (clk),
        .n_reset (n_reset),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_data ('0),
        .ld_en   (copy_en),
        .ld_data (copy_data),
        .rd_data (active_rd)
    );
`else
    coeff_bank #(
        .COEFF_W (COEFF_W)
    ) u_active_bank (
        .clk     (clk),
        .n_reset (n_reset),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (data_q),
        .ld_en   (1'b0),
        .ld_data ('0),
        .rd_data (active_rd)
    );
`endif

    assign modwait  = modwait_q;
    assign set_done = set_done_q;
    assign overrun  = overrun_q;
    assign coeff0   = active_rd[0];
    assign coeff1   = active_rd[1];
    assign coeff2   = active_rd[2];
    assign coeff3   = active_rd[3];

endmodule
